// File: rtl/present_ctr_core_if.sv
// Block stream handshake for the PRESENT CTR core:
// the input block channel and the result channel.
interface present_ctr_core_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/present_ctr_core.sv
// PRESENT-80/128 in counter mode: one cipher round per
// clock, keystream XORed with the latched input block.
module present_ctr_core #(
   parameter int KEY_W     = 80,
   parameter int CTR_INC_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                key_load,
   input  logic [KEY_W-1:0]    key,
   input  logic                iv_load,
   input  logic [63:0]         iv,
   present_ctr_core_if.slave   bus,
   output logic                busy
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key
      $error("present_ctr_core: KEY_W must be 80 or 128");
   end
   if (CTR_INC_W < 1 || CTR_INC_W > 64) begin : g_bad_ctr
      $error("present_ctr_core: CTR_INC_W must be 1..64");
   end

   function automatic logic [3:0] s_box(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;
         4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;
         4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;
         4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;
         4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++)
         y[6'(4*i) +: 4] = s_box(x[6'(4*i) +: 4]);
      return y;
   endfunction

   // Bit i lands on position 16*i mod 63; bit 63 stays put.
   function automatic logic [63:0] p_box(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 63; i++)
         y[6'((i*16) % 63)] = x[6'(i)];
      y[63] = x[63];
      return y;
   endfunction

   logic [1:0]       r_state;
   logic [KEY_W-1:0] r_key;
   logic [KEY_W-1:0] r_rk;
   logic [63:0]      r_ctr;
   logic [63:0]      r_data;
   logic [63:0]      r_din;
   logic [4:0]       r_round;
   logic             r_out_valid;
   logic [63:0]      r_out_data;

   logic [63:0]      w_rk_top;
   logic [KEY_W-1:0] w_rk_rot;
   logic [KEY_W-1:0] w_rk_nxt;
   logic [63:0]      w_ctr_nxt;
   logic             w_in_ready;
   logic             w_accept;

   assign w_rk_top = r_rk[KEY_W-1 -: 64];
   assign w_rk_rot = {r_rk[KEY_W-62:0], r_rk[KEY_W-1:KEY_W-61]};

   if (KEY_W == 128) begin : g_ks128
      always_comb begin
         w_rk_nxt            = w_rk_rot;
         w_rk_nxt[127:124]   = s_box(w_rk_rot[127:124]);
         w_rk_nxt[123:120]   = s_box(w_rk_rot[123:120]);
         w_rk_nxt[66:62]     = w_rk_rot[66:62] ^ r_round;
      end
   end else begin : g_ks80
      always_comb begin
         w_rk_nxt            = w_rk_rot;
         w_rk_nxt[79:76]     = s_box(w_rk_rot[79:76]);
         w_rk_nxt[19:15]     = w_rk_rot[19:15] ^ r_round;
      end
   end

   if (CTR_INC_W == 64) begin : g_ctr_full
      assign w_ctr_nxt = r_ctr + 64'd1;
   end else begin : g_ctr_part
      assign w_ctr_nxt = {r_ctr[63:CTR_INC_W],
                          r_ctr[CTR_INC_W-1:0] + CTR_INC_W'(1)};
   end

   assign w_in_ready = (r_state == S_IDLE) && !key_load && !iv_load;
   assign w_accept   = w_in_ready && bus.in_valid;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign busy          = (r_state == S_RUN) || (r_state == S_FIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_key       <= '0;
         r_rk        <= '0;
         r_ctr       <= '0;
         r_data      <= '0;
         r_din       <= '0;
         r_round     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (key_load) r_key <= key;
               if (iv_load)  r_ctr <= iv;
               if (w_accept) begin
                  r_din   <= bus.in_data;
                  r_data  <= r_ctr;
                  r_rk    <= r_key;
                  r_round <= 5'd1;
                  r_ctr   <= w_ctr_nxt;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_data  <= p_box(s_layer(r_data ^ w_rk_top));
               r_rk    <= w_rk_nxt;
               r_round <= r_round + 5'd1;
               if (r_round == 5'd31) r_state <= S_FIN;
            end
            // Last round key (K32) whitens the state here.
            S_FIN: begin
               r_out_data  <= r_data ^ w_rk_top ^ r_din;
               r_out_valid <= 1'b1;
               r_state     <= S_OUT;
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_present_ctr_core.sv
// Scoreboard bench for present_ctr_core: an 80-bit and a
// 128-bit instance driven with known PRESENT vectors.
module tb_present_ctr_core;
   typedef struct {
      logic [63:0] v;
      bit          differ;
      string       nm;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_load, iv_load;
   logic [79:0]  key80;
   logic [127:0] key128;
   logic [63:0]  iv;
   logic         busy80, busy128;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc80    = 0;
   int acc128   = 0;
   bit pv80     = 0;
   bit pv128    = 0;

   exp_t q80[$];
   exp_t q128[$];

   present_ctr_core_if b80 ();
   present_ctr_core_if b128 ();

   present_ctr_core #(.KEY_W(80), .CTR_INC_W(64)) dut80 (
      .clk(clk), .rst_n(rst_n),
      .key_load(key_load), .key(key80),
      .iv_load(iv_load), .iv(iv),
      .bus(b80), .busy(busy80)
   );

   present_ctr_core #(.KEY_W(128), .CTR_INC_W(64)) dut128 (
      .clk(clk), .rst_n(rst_n),
      .key_load(key_load), .key(key128),
      .iv_load(iv_load), .iv(iv),
      .bus(b128), .busy(busy128)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", nm, got, req);
      end
   endtask

   task automatic mon(input string tag, input logic [63:0] got,
                      inout exp_t q[$]);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         failures++;
         $display("FAIL %s_unexpected got=%h required=none", tag, got);
      end else begin
         e = q.pop_front();
         if (e.differ ? (got === e.v) : (got !== e.v)) begin
            failures++;
            $display("FAIL %s got=%h required=%s%h", e.nm, got,
                     e.differ ? "not " : "", e.v);
         end
      end
   endtask

   always @(negedge clk) begin
      if (b80.out_valid && !pv80)
         chk("latency80", 64'(cyc - acc80), 64'd32);
      pv80 = b80.out_valid;
      if (b80.out_valid && b80.out_ready)
         mon("out80", b80.out_data, q80);
   end

   always @(negedge clk) begin
      if (b128.out_valid && !pv128)
         chk("latency128", 64'(cyc - acc128), 64'd32);
      pv128 = b128.out_valid;
      if (b128.out_valid && b128.out_ready)
         mon("out128", b128.out_data, q128);
   end

   task automatic load(input logic [79:0] k80,
                       input logic [127:0] k128,
                       input logic [63:0] v);
      key80    = k80;
      key128   = k128;
      iv       = v;
      key_load = 1'b1;
      iv_load  = 1'b1;
      @(posedge clk); #1;
      key_load = 1'b0;
      iv_load  = 1'b0;
   endtask

   task automatic send(input bit s128, input logic [63:0] d,
                       input logic [63:0] e, input bit differ,
                       input bit push, input string nm);
      int   n;
      exp_t x;
      n = 0;
      x.v = e; x.differ = differ; x.nm = nm;
      if (push) begin
         if (s128) q128.push_back(x);
         else      q80.push_back(x);
      end
      if (s128) begin
         b128.in_valid = 1'b1; b128.in_data = d;
      end else begin
         b80.in_valid = 1'b1; b80.in_data = d;
      end
      @(negedge clk);
      while (!(s128 ? b128.in_ready : b80.in_ready) && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         checks++; failures++;
         $display("FAIL %s_accept_timeout got=0 required=1", nm);
      end
      @(posedge clk); #1;
      if (s128) acc128 = cyc;
      else      acc80  = cyc;
      b80.in_valid  = 1'b0;
      b128.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q80.size() != 0 || q128.size() != 0) && n < 300) begin
         n++;
         @(posedge clk);
      end
      if (n >= 300) begin
         checks++; failures++;
         $display("FAIL drain_timeout got=%0d required=0",
                  q80.size() + q128.size());
         q80.delete();
         q128.delete();
      end
      @(posedge clk); #1;
   endtask

   localparam logic [63:0] E0   = 64'h5579C1387B228445;
   localparam logic [63:0] EFK  = 64'hE72C46C0F5945049;
   localparam logic [63:0] EFP  = 64'hA112FFC72F68417B;
   localparam logic [63:0] E128 = 64'h96DB702A2E6900AF;
   localparam logic [63:0] ALLF = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      logic [63:0] snap;
      bit          bad;
      int          n;
      rst_n = 1'b0;
      key_load = 1'b0; iv_load = 1'b0;
      key80 = '0; key128 = '0; iv = '0;
      b80.in_valid = 1'b0;  b80.in_data = '0;  b80.out_ready = 1'b1;
      b128.in_valid = 1'b0; b128.in_data = '0; b128.out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 64'(b80.in_ready), 64'd1);
      chk("rst_out_valid", 64'(b80.out_valid), 64'd0);
      chk("rst_out_data", b80.out_data, 64'd0);
      chk("rst_busy", 64'(busy80), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      load('0, '0, '0);
      send(0, 64'd0, E0, 0, 1, "k0_iv0_blk1");
      send(0, 64'd0, E0, 1, 1, "k0_iv0_blk2_differs");
      drain();

      load('1, '0, '0);
      send(0, 64'd0, EFK, 0, 1, "kF_iv0");
      drain();

      load('0, '0, ALLF);
      send(0, 64'd0, EFP, 0, 1, "wrap_blk1");
      send(0, E0, 64'd0, 0, 1, "wrap_blk2_decrypt");
      drain();

      load('0, '0, ALLF);
      send(0, 64'd0, EFP, 0, 1, "ivrun_blk1");
      repeat (5) @(posedge clk);
      #1;
      iv = 64'h1234; iv_load = 1'b1;
      @(posedge clk); #1;
      iv_load = 1'b0;
      send(0, E0, 64'd0, 0, 1, "ivrun_ignored");
      drain();

      iv = '0; iv_load = 1'b1;
      b80.in_valid = 1'b1; b80.in_data = '0;
      @(negedge clk);
      chk("load_blocks_ready", 64'(b80.in_ready), 64'd0);
      @(posedge clk); #1;
      iv_load = 1'b0;
      send(0, 64'd0, E0, 0, 1, "load_priority");
      drain();

      b80.out_ready = 1'b0;
      load('0, '0, '0);
      send(0, 64'd0, E0, 0, 1, "backpressure");
      n = 0;
      while (!b80.out_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      snap = b80.out_data;
      bad = (n >= 100);
      repeat (100) begin
         @(negedge clk);
         if (b80.out_data !== snap || b80.in_ready !== 1'b0 ||
             b80.out_valid !== 1'b1)
            bad = 1'b1;
      end
      chk("backpressure_stable", 64'(bad), 64'd0);
      @(posedge clk); #1;
      b80.out_ready = 1'b1;
      drain();

      load('0, '0, '0);
      send(1, 64'd0, E128, 0, 1, "k128_zero");
      drain();

      load('0, '0, '0);
      send(0, 64'd0, E0, 0, 0, "discarded");
      repeat (14) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(b80.out_valid), 64'd0);
      chk("midrst_busy", 64'(busy80), 64'd0);
      chk("midrst_in_ready", 64'(b80.in_ready), 64'd1);
      @(negedge clk); rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      load('0, '0, '0);
      send(0, 64'd0, E0, 0, 1, "after_reset");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/present_ctr_core.md
# present_ctr_core

Parametrised PRESENT block cipher core in counter (CTR) mode, supporting 80- or 128-bit keys. It keeps a 64-bit counter block, encrypts it with one iterative PRESENT round per clock (31 rounds), and XORs the keystream with a 64-bit input block. CTR mode is symmetric, so the same core both encrypts and decrypts. Input and output use valid/ready handshakes. Key and IV are loaded through separate sideband pulses, and the counter advances once per accepted block.

## Interface
- KEY_W, 80: key length; legal values are 80 and 128 only; any other value is an elaboration error.
- CTR_INC_W, 64: number of low counter bits that increment, modulo 2^CTR_INC_W; bits [63:CTR_INC_W] stay fixed; legal range 1..64.
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_load  in  1  pulse; captures `key` into the key-hold register.
- key  in  KEY_W  cipher key.
- iv_load  in  1  pulse; captures `iv` into the counter.
- iv  in  64  initial counter block.
- in_valid  in  1  input block valid.
- in_ready  out  1  core can accept an input block.
- in_data  in  64  plaintext or ciphertext block.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  64  in_data XOR E_K(counter).
- busy  out  1  high in RUN and FIN.

## Operation
- FSM states: IDLE, RUN, FIN, OUT.
- IDLE:
  - in_ready = !key_load && !iv_load.
  - key_load and iv_load take effect only in IDLE; in any other state they are ignored.
  - Accept (in_valid && in_ready):
    - latch in_data;
    - data reg ← counter;
    - round key reg ← key-hold;
    - round ← 1;
    - counter low CTR_INC_W bits ← +1, wrapping;
    - go to RUN.
- RUN, one round per cycle:
  - data reg ← pLayer(sBox(data ^ rk[KEY_W-1:KEY_W-64])).
  - Key schedule for KEY_W=80:
    - rotate left 61;
    - S-box on [79:76];
    - XOR [19:15] with round.
  - Key schedule for KEY_W=128:
    - rotate left 61;
    - S-box on [127:124] and on [123:120];
    - XOR [66:62] with round.
  - round increments each cycle; when round==31 completes, go to FIN.
- FIN:
  - out_data ← data ^ rk[KEY_W-1:KEY_W-64] ^ latched in_data (final key, K32);
  - out_valid ← 1; go to OUT.
- OUT:
  - out_valid and out_data are held stable until out_ready.
  - On handshake: out_valid ← 0, go to IDLE.
  - Backpressure may stall indefinitely with no loss.
- S-box and P-layer reuse the team's existing s_box and p_box cells:
  - 16 S-boxes in the datapath;
  - 1 S-box for KEY_W=80, 2 for KEY_W=128, in the key path.
- Round key is recomputed from key-hold for every block; key-hold is never modified by the schedule.

## Timing
- Reset values:
  - state IDLE, so in_ready=1 when no load pulse is present;
  - out_valid=0, out_data=0, busy=0;
  - counter=0, key-hold=0, round=0, data reg=0.
- Reset asserted mid-block: the block is discarded immediately, the FSM returns to IDLE, and the counter returns to 0. A new key/IV must be loaded.
- Accept edge is cycle 0; round edges are 1..31; FIN edge is 32.
- out_valid is high after edge 32 (latency 32 cycles), and for at least one cycle.
- Minimum block period is 34 cycles, reached when out_ready is held at 1 (OUT→IDLE edge, then IDLE accept).
- A load pulse coinciding with in_valid in IDLE takes priority: the block is not accepted that cycle. The load pulse applies at that edge, and acceptance can occur the next cycle.
- key_load and iv_load asserted together both take effect.
- Counter wrap: with CTR_INC_W=64, 0xFFFF_FFFF_FFFF_FFFF → 0. With CTR_INC_W<64, the upper bits never change on wrap.
- The counter value used by a block is the pre-increment value.

## Test plan
- KEY_W=80, key=0, iv=0, in_data=0:
  - block 1 → out_data=0x5579C1387B228445, out_valid first high 32 cycles after accept;
  - block 2 (same inputs) → must differ from block 1, showing the counter advanced.
- KEY_W=80, key=all-F, iv=0, in_data=0 → 0xE72C46C0F5945049.
- Wrap: KEY_W=80, key=0, iv=all-F:
  - block 1 with in_data=0 → 0xA112FFC72F68417B;
  - block 2 with in_data=0x5579C1387B228445 → 0x0 (counter wrapped to 0, decrypt symmetry).
- KEY_W=128, key=0, iv=0, in_data=0 → 0x96DB702A2E6900AF.
- Backpressure and sideband:
  - out_ready low 100 cycles → out_data stable, in_ready low throughout;
  - iv_load in RUN → ignored (next block uses the incremented counter);
  - iv_load coinciding with in_valid in IDLE → no accept that cycle.
- rst_n pulse at round 15 → out_valid stays 0, busy=0 and in_ready=1 immediately; after key=0, iv=0 reload, in_data=0 → 0x5579C1387B228445.
